// File: rtl/dbus_sram_resp_pkg.sv
// Shared data-bus types for the SRAM responder: request/response structs and access sizes.
package dbus_sram_resp_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    // Natural alignment: words on 4-byte, halfwords on 2-byte boundaries.
    function automatic logic is_misaligned(input logic [1:0] lo, input msize_t size);
        return ((size == MSIZE4) && (lo != 2'b00)) || ((size == MSIZE2) && lo[0]);
    endfunction

endpackage

// File: rtl/dbus_sram_resp_bank.sv
// DEPTH x 32 backing store: per-byte write enables, asynchronous read, no reset.
module dbus_sram_bank #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [3:0]               we,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dbus_sram_resp.sv
// Fixed-latency SRAM responder on the data bus, one request outstanding.
// Define DBUS_RESP_ALIGN_CHECK_EN to reject misaligned word/halfword accesses.
module dbus_sram_resp
    import dbus_sram_resp_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       busy,
    output logic       align_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] lat_idx;
    logic [1:0]    lat_lo;
    msize_t        lat_size;
    logic [3:0]    lat_strobe;
    logic [31:0]   lat_data;

    logic          is_write;
    logic          misaligned;
    logic [3:0]    bank_we;
    logic [31:0]   bank_rdata;
    logic          unused_bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lat_idx    <= '0;
            lat_lo     <= '0;
            lat_size   <= MSIZE1;
            lat_strobe <= '0;
            lat_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dreq.valid) begin
                        lat_idx    <= dreq.addr[2 +: AW];
                        lat_lo     <= dreq.addr[1:0];
                        lat_size   <= dreq.size;
                        lat_strobe <= dreq.strobe;
                        lat_data   <= dreq.data;
                        cnt        <= 4'(LATENCY - 1);
                        state      <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign is_write = (lat_strobe != 4'h0);

`ifdef DBUS_RESP_ALIGN_CHECK_EN
    assign misaligned = is_misaligned(lat_lo, lat_size);
    assign align_err  = (state == S_RESP) && misaligned;
`else
    assign misaligned = 1'b0;
    assign align_err  = 1'b0;
`endif

    // Reset dominates a coincident RESP cycle so a dropped request never reaches memory.
    assign bank_we = (state == S_RESP && !reset && !misaligned) ? lat_strobe : 4'h0;

    dbus_sram_bank #(.DEPTH(DEPTH)) u_bank (
        .clk   (clk),
        .addr  (lat_idx),
        .we    (bank_we),
        .wdata (lat_data),
        .rdata (bank_rdata)
    );

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = (state == S_IDLE) && dreq.valid;
        dresp.data_ok = (state == S_RESP);
        if (state == S_RESP && !is_write && !misaligned) begin
            dresp.data = bank_rdata;
        end
    end

    assign busy = (state != S_IDLE);

    // Upper address bits wrap away; size/low bits matter only with the alignment check.
    assign unused_bits = ^{dreq.addr[31:2+AW], lat_lo, lat_size};

endmodule
